// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller: debounces the run and step buttons and issues
// one-cycle CPU enable pulses in free-run (every DIV clocks) or single-step mode.
module cpu_run_ctrl #(
    parameter int unsigned DIV       = 2500000,
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop,
    input  logic        run_btn,
    input  logic        step_btn,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [31:0] cycle_cnt
);

    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DbW  = $clog2(DB_CYCLES + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DB_CYCLES - 1);

    // StBrkStep is the forced pulse when resuming from a breakpoint; it reports as STEP.
    typedef enum logic [2:0] {StHalt, StRun, StStep, StBrk, StBrkStep} state_e;

    // Bit 0 is the run button, bit 1 the step button.
    logic [1:0]     btn_raw;
    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     db_q, db_prev_q;
    logic [DbW-1:0] db_cnt_q [2];
    logic           run_ev, step_ev;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            cpu_en_q, cpu_en_d;
    logic [1:0]      state_out_q, state_out_d;
    logic [31:0]     cycle_cnt_q;
    logic            tick;

    assign btn_raw = {step_btn, run_btn};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbLast) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Events fire only on the debounced press, never on release.
    assign run_ev  = db_q[0] & ~db_prev_q[0];
    assign step_ev = db_q[1] & ~db_prev_q[1];

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        cpu_en_d    = 1'b0;
        state_out_d = 2'b00;
        tick        = (state_q == StRun) && (div_cnt_q == DivLast);

        if (state_q == StRun) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end

        if (stop) begin
            state_d = StHalt;
        end else begin
            unique case (state_q)
                StHalt: begin
                    if (run_ev) begin
                        state_d = StRun;
                    end else if (step_ev) begin
                        state_d  = StStep;
                        cpu_en_d = 1'b1;
                    end
                end
                StRun: begin
                    if (tick) begin
                        if (bp_en && (pc == bp_addr)) begin
                            state_d = StBrk;
                        end else begin
                            cpu_en_d = 1'b1;
                        end
                    end
                end
                StStep:    state_d = StHalt;
                StBrk: begin
                    if (run_ev) begin
                        state_d  = StBrkStep;
                        cpu_en_d = 1'b1;
                    end else if (step_ev) begin
                        state_d  = StStep;
                        cpu_en_d = 1'b1;
                    end
                end
                StBrkStep: state_d = StRun;
                default:   state_d = StHalt;
            endcase
        end

        if ((state_d == StRun) && (state_q != StRun)) begin
            div_cnt_d = '0;
        end

        case (state_d)
            StHalt:            state_out_d = 2'b00;
            StRun:             state_out_d = 2'b01;
            StStep, StBrkStep: state_out_d = 2'b10;
            StBrk:             state_out_d = 2'b11;
            default:           state_out_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHalt;
            state_out_q <= 2'b00;
            div_cnt_q   <= '0;
            cpu_en_q    <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            state_out_q <= state_out_d;
            div_cnt_q   <= div_cnt_d;
            cpu_en_q    <= cpu_en_d;
            cycle_cnt_q <= cycle_cnt_q + {31'b0, cpu_en_q};
        end
    end

    assign cpu_en    = cpu_en_q;
    assign state     = state_out_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: behavioural model compared every cycle, directed scenarios
// with literal expectations, then a randomized phase.
module tb_cpu_run_ctrl;

    localparam int DIV = 4;
    localparam int DB  = 3;
    localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_BRK = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stop = 1'b0;
    logic        run_btn = 1'b0;
    logic        step_btn = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = '0;
    logic [31:0] pc = '0;
    logic        cpu_en;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    bit pc_clear = 1'b0;
    bit cnt_force = 1'b0;
    int en_seen = 0;
    int at_c = 0;

    // Behavioural model state.
    bit          m_sync [2][2];
    bit          m_db [2];
    int          m_n [2];
    bit          m_rise [2];
    int          m_mode = M_HALT;
    bit          m_forced = 1'b0;
    longint      m_age = 0;
    bit          m_en = 1'b0;
    logic [31:0] m_cnt = '0;
    bit          m_ren, m_sen, m_en_next;
    bit          m_b [2];

    cpu_run_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .stop      (stop),
        .run_btn   (run_btn),
        .step_btn  (step_btn),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .cpu_en    (cpu_en),
        .state     (state),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        m_b[0] = run_btn;
        m_b[1] = step_btn;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_sync[i][0] = 0; m_sync[i][1] = 0; m_db[i] = 0; m_n[i] = 0; m_rise[i] = 0;
            end
            m_mode = M_HALT; m_forced = 0; m_age = 0; m_en = 0; m_cnt = '0;
        end else begin
            m_ren = m_rise[0];
            m_sen = m_rise[1];
            m_en_next = 0;
            if (stop) begin
                m_mode = M_HALT;
                m_forced = 0;
            end else begin
                case (m_mode)
                    M_HALT: if (m_ren) begin m_mode = M_RUN; m_age = 0; end
                            else if (m_sen) begin m_mode = M_STEP; m_en_next = 1; end
                    M_RUN: begin
                        if (m_age % DIV == DIV - 1) begin
                            if (bp_en && pc == bp_addr) m_mode = M_BRK;
                            else m_en_next = 1;
                        end
                        m_age++;
                    end
                    M_STEP: if (m_forced) begin m_mode = M_RUN; m_age = 0; m_forced = 0; end
                            else m_mode = M_HALT;
                    default: if (m_ren) begin m_mode = M_STEP; m_forced = 1; m_en_next = 1; end
                             else if (m_sen) begin m_mode = M_STEP; m_en_next = 1; end
                endcase
            end
            m_cnt = cnt_force ? 32'hFFFF_FFFF : m_cnt + (m_en ? 32'd1 : 32'd0);
            m_en  = m_en_next;
            for (int i = 0; i < 2; i++) begin
                m_rise[i] = 0;
                if (m_sync[i][1] != m_db[i]) begin
                    m_n[i]++;
                    if (m_n[i] == DB) begin
                        m_db[i] = m_sync[i][1]; m_n[i] = 0; m_rise[i] = m_db[i];
                    end
                end else begin
                    m_n[i] = 0;
                end
                m_sync[i][1] = m_sync[i][0];
                m_sync[i][0] = m_b[i];
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (chk_en) begin
            check("state", {30'b0, state}, m_mode[31:0]);
            check("cpu_en", {31'b0, cpu_en}, {31'b0, m_en});
            check("cycle_cnt", cycle_cnt, m_cnt);
        end
    end

    // Simple CPU: PC advances by 4 on every enable pulse.
    always @(posedge clk) begin
        #2;
        if (cpu_en === 1'b1) begin
            en_seen++;
            if (pc == 32'h0000_000C) at_c++;
        end
        if (pc_clear) pc = '0;
        else if (cpu_en === 1'b1) pc = pc + 32'd4;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
    endtask

    task automatic wait_run(input string name);
        int n = 0;
        while (state != 2'b01 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, state == 2'b01}, 32'd1);
    endtask

    initial begin
        int entries, pulses, first, rc, base, base_c, step_cyc, brk_step, hold_r, hold_s;
        logic [1:0] prev;

        // Reset state.
        do_reset();
        chk_en = 1'b1;
        check("rst_state", {30'b0, state}, 32'd0);
        check("rst_en", {31'b0, cpu_en}, 32'd0);
        check("rst_cnt", cycle_cnt, 32'd0);

        // Run button held 10 cycles: one RUN entry, pulse every 4th cycle.
        run_btn = 1'b1;
        entries = 0; pulses = 0; first = -1; rc = -1; prev = 2'b00;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 10) run_btn = 1'b0;
            if (state == 2'b01 && prev != 2'b01) entries++;
            prev = state;
            if (rc < 0 && state == 2'b01) rc = 0;
            else if (rc >= 0) rc++;
            if (rc >= 0 && rc <= 20 && cpu_en) begin
                pulses++;
                if (first < 0) first = rc;
            end
            if (rc == 21) begin
                check("run_cnt5", cycle_cnt, 32'd5);
                check("model_cnt5", m_cnt, 32'd5);
            end
        end
        check("run_entries", entries, 32'd1);
        check("run_pulses", pulses, 32'd5);
        check("run_first", first, 32'd4);
        stop = 1'b1;
        cycles(2);
        stop = 1'b0;

        // Bouncing step button then a clean press: exactly one step.
        do_reset();
        step_cyc = 0; base = en_seen;
        for (int k = 0; k < 35; k++) begin
            step_btn = (k < 10) ? (k % 2 == 0) : 1'b1;
            @(negedge clk);
            if (state == 2'b10) step_cyc++;
        end
        check("step_cycles", step_cyc, 32'd1);
        check("step_pulses", en_seen - base, 32'd1);
        check("step_cnt", cycle_cnt, 32'd1);
        check("step_halt", {30'b0, state}, 32'd0);
        step_btn = 1'b0;
        cycles(8);

        // Breakpoint at 0x0C.
        do_reset();
        pc_clear = 1'b1; bp_en = 1'b1; bp_addr = 32'h0000_000C;
        run_btn = 1'b1;
        base = en_seen; base_c = at_c;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            pc_clear = 1'b0;
            if (k == 10) run_btn = 1'b0;
        end
        check("bp_state", {30'b0, state}, 32'd3);
        check("bp_pulses", en_seen - base, 32'd3);
        check("bp_pc", pc, 32'h0000_000C);
        run_btn = 1'b1;
        brk_step = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 10) run_btn = 1'b0;
            if (state == 2'b10) brk_step++;
        end
        check("bp_resume_step", brk_step, 32'd1);
        check("bp_pulse_at_c", at_c - base_c, 32'd1);
        check("bp_resume_run", {30'b0, state}, 32'd1);
        check("bp_total_pulses", en_seen - base, 32'd12);
        check("bp_pc_final", pc, 32'h0000_0030);
        bp_en = 1'b0;
        stop = 1'b1;
        cycles(2);
        stop = 1'b0;

        // Stop one cycle before a tick, and run presses during stop.
        do_reset();
        base = en_seen;
        run_btn = 1'b1;
        wait_run("stop_wait_run");
        cycles(2);
        stop = 1'b1; run_btn = 1'b0;
        @(negedge clk);
        check("stop_state", {30'b0, state}, 32'd0);
        check("stop_en", {31'b0, cpu_en}, 32'd0);
        cycles(8);
        run_btn = 1'b1;
        cycles(8);
        run_btn = 1'b0;
        cycles(8);
        stop = 1'b0;
        cycles(20);
        check("stop_ignored_state", {30'b0, state}, 32'd0);
        check("stop_no_pulse", en_seen - base, 32'd0);

        // Counter wrap.
        do_reset();
        @(negedge clk);
        cnt_force = 1'b1;
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cycle_cnt_q;
        cnt_force = 1'b0;
        check("wrap_pre", cycle_cnt, 32'hFFFF_FFFF);
        step_btn = 1'b1;
        cycles(10);
        step_btn = 1'b0;
        cycles(10);
        check("wrap_post", cycle_cnt, 32'h0000_0000);

        // Reset during RUN.
        do_reset();
        run_btn = 1'b1;
        wait_run("rstrun_wait_run");
        cycles(4);
        run_btn = 1'b0;
        cycles(6);
        check("rstrun_pre_cnt", cycle_cnt, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            check("rstrun_quiet", {cycle_cnt[28:0], cpu_en, state}, 32'd0);
            @(negedge clk);
        end

        // Randomized phase.
        do_reset();
        hold_r = 0; hold_s = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            if (stop) stop = ($urandom_range(0, 3) != 0);
            else stop = ($urandom_range(0, 79) == 0);
            if (hold_r == 0) begin
                run_btn = 1'($urandom_range(0, 1));
                hold_r = $urandom_range(1, 10);
            end else hold_r--;
            if (hold_s == 0) begin
                step_btn = 1'($urandom_range(0, 1));
                hold_s = $urandom_range(1, 10);
            end else hold_s--;
            if ($urandom_range(0, 99) == 0) begin
                bp_en = 1'($urandom_range(0, 1));
                bp_addr = 32'($urandom_range(0, 15)) << 2;
            end
            pc_clear = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        pc_clear = 1'b0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 2500000: clk cycles per free-run CPU enable pulse (legal range 2..2^24).
REQ-002 SHALL have parameter DB_CYCLES, default 500000: cycles a button must hold stable to be accepted (legal range 1..2^20).
REQ-003 SHALL have port clk, input, 1: single clock; board clock domain.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port stop, input, 1: level; high forces and holds HALT.
REQ-006 SHALL have port run_btn, input, 1: raw run pushbutton, asynchronous.
REQ-007 SHALL have port step_btn, input, 1: raw single-step pushbutton, asynchronous.
REQ-008 SHALL have port bp_en, input, 1: breakpoint enable.
REQ-009 SHALL have port bp_addr, input, 32: breakpoint PC.
REQ-010 SHALL have port pc, input, 32: current CPU PC.
REQ-011 SHALL have port cpu_en, output, 1: one-clk CPU advance pulse.
REQ-012 SHALL have port state, output, 2: 00 HALT, 01 RUN, 10 STEP, 11 BRK.
REQ-013 SHALL have port cycle_cnt, output, 32: count of cpu_en pulses issued.

Function
REQ-014 SHALL pass run_btn and step_btn each through a 2-flop synchronizer, then a debouncer; a debounced value changes only after the synchronized input differs from it for DB_CYCLES consecutive cycles.
REQ-015 SHALL generate run_ev / step_ev as one-cycle pulses on the debounced 0->1 edge only; release and bounce produce no event.
REQ-016 SHALL use divider counter div_cnt of $clog2(DIV) bits: counts 0..DIV-1 in RUN only and wraps to 0; tick = (div_cnt == DIV-1); div_cnt is cleared on every entry to RUN.
REQ-017 SHALL, in HALT: cpu_en=0; run_ev -> RUN; else step_ev -> STEP.
REQ-018 SHALL, in RUN, on a tick with bp_en=1 and pc==bp_addr: withhold cpu_en and go to BRK (stop before executing bp instruction).
REQ-019 SHALL, in RUN, on a tick otherwise: assert cpu_en for that one cycle and stay in RUN; no cpu_en on non-tick cycles.
REQ-020 SHALL, in STEP: assert cpu_en for exactly the one cycle spent in STEP, ignoring breakpoint, then go to HALT.
REQ-021 SHALL, in BRK: cpu_en=0; run_ev -> one forced pulse (breakpoint ignored) via STEP-like cycle then RUN; step_ev -> STEP.
REQ-022 SHALL give stop=1 priority over all events: every state goes to HALT the next cycle, cpu_en=0 in the cycle stop is sampled high; events arriving while stop=1 are discarded.
REQ-023 SHALL give run_ev priority when run_ev and step_ev occur in the same cycle.
REQ-024 SHALL ignore run_ev in RUN and step_ev in RUN/STEP.
REQ-025 SHALL increment cycle_cnt by 1 in the cycle after each cpu_en pulse, wrapping modulo 2^32 (0xFFFFFFFF -> 0).
REQ-026 SHALL register all outputs (no combinational path from inputs to cpu_en or state).

Reset
REQ-027 SHALL, when rst=1 at a clk edge: state=HALT, cpu_en=0, cycle_cnt=0, div_cnt=0, synchronizers, debounced values and debounce counters=0, all pending events dropped.
REQ-028 SHALL apply rst mid-RUN or mid-STEP with no further cpu_en pulse after the reset edge.

Verification (DIV=4, DB_CYCLES=3)
REQ-029 SHALL cover reset then run_btn held 10 cycles -> RUN entered once; cpu_en every 4th cycle; cycle_cnt=5 after 20 RUN cycles.
REQ-030 SHALL cover step_btn toggling 1/0 every cycle for 10 cycles, then held 1 -> exactly one STEP, one cpu_en pulse, cycle_cnt=1, state back to 00.
REQ-031 SHALL cover bp_en=1, bp_addr=0x0000000C, pc advancing by 4 per pulse from 0 -> 3 pulses, state=11 with pc=0x0C; a further run_btn -> pulse at pc=0x0C, then RUN continues.
REQ-032 SHALL cover stop asserted in RUN one cycle before a tick -> no cpu_en, state=00 next cycle; run_btn during stop -> ignored.
REQ-033 SHALL cover cycle_cnt forced to 0xFFFFFFFF (via backdoor) plus one step -> cycle_cnt=0x00000000.
REQ-034 SHALL cover rst asserted during RUN -> state=00, cycle_cnt=0, cpu_en=0 for all following cycles until a new run_ev.
